// File: rtl/life_gen_engine_pkg.sv
// Shared types for the Game-of-Life generation engine: FSM encoding and the B3/S23 cell rule.
`ifndef LIFE_STATE
`define LIFE_STATE 1:0
`endif

package life_gen_engine_pkg;

    typedef enum logic [`LIFE_STATE] {
        LIFE_IDLE = 2'd0,
        LIFE_ROW  = 2'd1,
        LIFE_DONE = 2'd2
    } life_state_t;

    // Birth on exactly 3 neighbours, survival on 2 or 3.
    function automatic logic life_rule(input logic alive, input logic [3:0] cnt);
        return (cnt == 4'd3) | (alive & (cnt == 4'd2));
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation rule for one N-bit row, with toroidal column wrap.
module life_row_next
    import life_gen_engine_pkg::*;
#(
    parameter int K = 6
) (
    input  logic [2**K-1:0] prev_row,
    input  logic [2**K-1:0] cur_row,
    input  logic [2**K-1:0] next_row,
    output logic [2**K-1:0] new_row
);

    localparam int N = 2**K;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_col
            localparam int CL = (gi + N - 1) % N;
            localparam int CR = (gi + 1) % N;
            logic [3:0] cnt;

            assign cnt = {3'b0, prev_row[CL]} + {3'b0, prev_row[gi]} + {3'b0, prev_row[CR]}
                       + {3'b0, cur_row[CL]}                         + {3'b0, cur_row[CR]}
                       + {3'b0, next_row[CL]} + {3'b0, next_row[gi]} + {3'b0, next_row[CR]};

            assign new_row[gi] = life_rule(cur_row[gi], cnt);
        end
    endgenerate

endmodule

// File: rtl/life_gen_engine.sv
// Game-of-Life board store: single-cell edits in IDLE, one in-place generation per step edge,
// one row per cycle, plus a registered display read port.
module life_gen_engine
    import life_gen_engine_pkg::*;
#(
    parameter int K     = 6,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             write_en,
    input  logic [K-1:0]     wAddrR,
    input  logic [K-1:0]     wAddrC,
    input  logic             write_data,
    input  logic [K-1:0]     rAddrR,
    input  logic [K-1:0]     rAddrC,
    output logic             rd_data,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count
);

    localparam int N = 2**K;
    localparam logic [K-1:0] LAST_ROW = K'(N - 1);

    logic [N-1:0]     board_reg [N];
    logic [N-1:0]     save_prev_reg;
    logic [N-1:0]     save_row0_reg;
    life_state_t      state_reg;
    logic [K-1:0]     r_reg;
    logic             pend_reg;
    logic             step_q;
    logic             rd_data_reg;
    logic             busy_reg;
    logic             gen_done_reg;
    logic [GEN_W-1:0] gen_count_reg;

    logic [K-1:0] r_plus1;
    logic [N-1:0] prev_row;
    logic [N-1:0] cur_row;
    logic [N-1:0] next_row;
    logic [N-1:0] new_row;
    logic         req;

    assign req     = step & ~step_q;
    assign r_plus1 = r_reg + 1'b1;

    // Rows above/below come from the old generation: the saved copies stand in
    // for rows that have already been overwritten in place.
    assign prev_row = (r_reg == '0) ? board_reg[N-1] : save_prev_reg;
    assign cur_row  = board_reg[r_reg];
    assign next_row = (r_reg == LAST_ROW) ? save_row0_reg : board_reg[r_plus1];

    life_row_next #(.K(K)) u_row_next (
        .prev_row (prev_row),
        .cur_row  (cur_row),
        .next_row (next_row),
        .new_row  (new_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                board_reg[i] <= '0;
            end
            save_prev_reg <= '0;
            save_row0_reg <= '0;
            state_reg     <= LIFE_IDLE;
            r_reg         <= '0;
            pend_reg      <= 1'b0;
            step_q        <= 1'b0;
            rd_data_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            gen_done_reg  <= 1'b0;
            gen_count_reg <= '0;
        end else begin
            step_q       <= step;
            rd_data_reg  <= board_reg[rAddrR][rAddrC];
            gen_done_reg <= 1'b0;

            case (state_reg)
                LIFE_IDLE: begin
                    if (write_en) begin
                        board_reg[wAddrR][wAddrC] <= write_data;
                    end
                    if (req || pend_reg) begin
                        state_reg <= LIFE_ROW;
                        r_reg     <= '0;
                        pend_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end

                LIFE_ROW: begin
                    board_reg[r_reg] <= new_row;
                    save_prev_reg    <= cur_row;
                    if (r_reg == '0) begin
                        save_row0_reg <= cur_row;
                    end
                    if (req) begin
                        pend_reg <= 1'b1;
                    end
                    if (r_reg == LAST_ROW) begin
                        state_reg     <= LIFE_DONE;
                        gen_done_reg  <= 1'b1;
                        gen_count_reg <= gen_count_reg + GEN_W'(1);
                    end else begin
                        r_reg <= r_plus1;
                    end
                end

                LIFE_DONE: begin
                    if (pend_reg) begin
                        state_reg <= LIFE_ROW;
                        r_reg     <= '0;
                        pend_reg  <= 1'b0;
                    end else begin
                        // A fresh request here is remembered and launched from IDLE.
                        state_reg <= LIFE_IDLE;
                        busy_reg  <= 1'b0;
                        if (req) begin
                            pend_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= LIFE_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = rd_data_reg;
    assign busy      = busy_reg;
    assign gen_done  = gen_done_reg;
    assign gen_count = gen_count_reg;

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench for life_gen_engine: blinker, wrapping glider, still life, pending/drop,
// simultaneous edit+step, reset mid-generation and generation-counter wrap.
module tb_life_gen_engine;

    localparam int K     = 6;
    localparam int N     = 64;
    localparam int GEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             step = 1'b0;
    logic             write_en = 1'b0;
    logic [K-1:0]     wAddrR = '0;
    logic [K-1:0]     wAddrC = '0;
    logic             write_data = 1'b0;
    logic [K-1:0]     rAddrR = '0;
    logic [K-1:0]     rAddrC = '0;
    logic             rd_data;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;

    int checks = 0;
    int errors = 0;
    bit model [N][N];

    always #5 clk = ~clk;

    life_gen_engine #(.K(K), .GEN_W(GEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .write_en   (write_en),
        .wAddrR     (wAddrR),
        .wAddrC     (wAddrC),
        .write_data (write_data),
        .rAddrR     (rAddrR),
        .rAddrC     (rAddrC),
        .rd_data    (rd_data),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: got %0d", tag, got);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                model[r][c] = 1'b0;
    endtask

    // Whole-board reference generation with wrap in both dimensions.
    task automatic model_step();
        bit tmp [N][N];
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(model[(r + dr + N) % N][(c + dc + N) % N]);
                tmp[r][c] = (n == 3) || (model[r][c] && n == 2);
            end
        end
        model = tmp;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; step = 1'b0; write_en = 1'b0; write_data = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_cell(input int r, input int c, input bit v);
        @(negedge clk);
        write_en = 1'b1; wAddrR = K'(r); wAddrC = K'(c); write_data = v;
        @(negedge clk);
        write_en = 1'b0;
        model[r][c] = v;
    endtask

    task automatic read_cell(input int r, input int c, output bit v);
        @(negedge clk);
        rAddrR = K'(r); rAddrC = K'(c);
        @(posedge clk);
        #1 v = rd_data;
    endtask

    task automatic compare_board(input string tag);
        int bad = 0;
        bit v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                read_cell(r, c, v);
                if (v != model[r][c]) bad++;
            end
        check(tag, bad, 0);
    endtask

    // Single-cycle step pulse; returns just after the sampling edge e0.
    task automatic step_edge(input string tag);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 check({tag, "_busy_start"}, int'(busy), 1);
        @(negedge clk);
        step = 1'b0;
        model_step();
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int  n = 0;
        bit  seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            #1 n++;
            seen = gen_done;
        end
        check({tag, "_latency"}, seen ? n : -1, exp_lat);
        @(posedge clk);
        #1 check({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic place_blinker();
        write_cell(10, 9, 1'b1);
        write_cell(10, 10, 1'b1);
        write_cell(10, 11, 1'b1);
    endtask

    initial begin
        bit v;
        int ndone, d1, d2;

        // Reset state
        do_reset();
        #1 check("rst_busy", int'(busy), 0);
        check("rst_gen_done", int'(gen_done), 0);
        check("rst_gen_count", int'(gen_count), 0);
        read_cell(10, 10, v);
        check("rst_rd_data", int'(v), 0);

        // Blinker: horizontal -> vertical
        place_blinker();
        step_edge("blinker");
        wait_done("blinker", 64);
        check("blinker_gen_count", int'(gen_count), 1);
        read_cell(9, 10, v);  check("blinker_9_10", int'(v), 1);
        read_cell(11, 10, v); check("blinker_11_10", int'(v), 1);
        read_cell(10, 9, v);  check("blinker_10_9", int'(v), 0);
        read_cell(10, 11, v); check("blinker_10_11", int'(v), 0);
        compare_board("blinker_board");

        // Glider straddling both wrap seams, 4 generations -> shifted (+1,+1)
        do_reset();
        write_cell(62, 63, 1'b1);
        write_cell(63, 0, 1'b1);
        write_cell(0, 62, 1'b1);
        write_cell(0, 63, 1'b1);
        write_cell(0, 0, 1'b1);
        for (int g = 0; g < 4; g++) begin
            step_edge("glider");
            wait_done("glider", 64);
        end
        check("glider_gen_count", int'(gen_count), 4);
        read_cell(63, 0, v); check("glider_63_0", int'(v), 1);
        read_cell(0, 1, v);  check("glider_0_1", int'(v), 1);
        read_cell(1, 63, v); check("glider_1_63", int'(v), 1);
        read_cell(1, 0, v);  check("glider_1_0", int'(v), 1);
        read_cell(1, 1, v);  check("glider_1_1", int'(v), 1);
        read_cell(62, 63, v); check("glider_62_63", int'(v), 0);
        compare_board("glider_board");

        // Block still life with step held high
        do_reset();
        write_cell(0, 0, 1'b1);
        write_cell(0, 1, 1'b1);
        write_cell(1, 0, 1'b1);
        write_cell(1, 1, 1'b1);
        ndone = 0;
        @(negedge clk);
        step = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 if (gen_done) ndone++;
        end
        @(negedge clk);
        step = 1'b0;
        model_step();
        check("block_done_pulses", ndone, 1);
        check("block_gen_count", int'(gen_count), 1);
        compare_board("block_board");

        // Pending request, dropped third request, dropped write during busy
        do_reset();
        place_blinker();
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        ndone = 0; d1 = -1; d2 = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            step = (k == 10 || k == 20);
            write_en = (k == 30);
            wAddrR = K'(30); wAddrC = K'(30); write_data = 1'b1;
            @(posedge clk);
            #1 if (gen_done) begin
                ndone++;
                if (ndone == 1) d1 = k;
                else if (ndone == 2) d2 = k;
            end
        end
        @(negedge clk);
        step = 1'b0; write_en = 1'b0;
        model_step();
        model_step();
        check("pend_done_pulses", ndone, 2);
        check("pend_first_done", d1, 64);
        check("pend_second_done", d2, 129);
        check("pend_gen_count", int'(gen_count), 2);
        check("pend_idle", int'(busy), 0);
        read_cell(30, 30, v); check("pend_busy_write_dropped", int'(v), 0);
        compare_board("pend_board");

        // Write and step edge in the same IDLE cycle
        do_reset();
        @(negedge clk);
        write_en = 1'b1; wAddrR = K'(5); wAddrC = K'(5); write_data = 1'b1; step = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write_en = 1'b0; step = 1'b0;
        model[5][5] = 1'b1;
        model_step();
        wait_done("simul", 64);
        read_cell(5, 5, v); check("simul_5_5", int'(v), 0);
        check("simul_gen_count", int'(gen_count), 1);
        compare_board("simul_board");

        // Reset mid-generation
        do_reset();
        place_blinker();
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
        for (int k = 1; k < 30; k++) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("midrst_busy", int'(busy), 0);
        check("midrst_gen_count", int'(gen_count), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 if (gen_done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_idle", int'(busy), 0);
        compare_board("midrst_board");

        // Generation counter wrap (GEN_W = 4 here)
        do_reset();
        for (int g = 0; g < 15; g++) begin
            step_edge("wrap");
            wait_done("wrap", 64);
        end
        check("wrap_count_15", int'(gen_count), 15);
        step_edge("wrap");
        wait_done("wrap", 64);
        check("wrap_count_0", int'(gen_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_gen_engine.md
# life_gen_engine

Board store and generation engine that sits directly downstream of the evolve control block. It holds the N×N Game-of-Life board, applies single-cell edit writes from the control path, and computes one new generation (rule B3/S23, toroidal wrap) on each rising edge of the upstream `change_state` level. It also serves a registered read port to the display path.

## Interface
Parameters:
- K, 6, address width; board is N×N with N = 2**K
- GEN_W, 16, width of generation counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous assert, active-high
- step  in  1  upstream `change_state` level; a generation is requested on each 0→1 transition
- write_en  in  1  edit write strobe
- wAddrR  in  K  edit row
- wAddrC  in  K  edit column
- write_data  in  1  cell value to write
- rAddrR  in  K  display read row
- rAddrC  in  K  display read column
- rd_data  out  1  cell at (rAddrR, rAddrC), registered
- busy  out  1  high while a generation is in progress (state ≠ IDLE)
- gen_done  out  1  one-cycle pulse when a generation completes
- gen_count  out  GEN_W  completed generations, wraps modulo 2**GEN_W

## Operation
- Storage: N row registers of N bits, single bank, updated in place.
- Step detect: `step_q` registers `step`. A request is `step & ~step_q`. A held-high `step` yields exactly one request.
- States: IDLE, ROW, DONE.
- IDLE → ROW on a request, or on `pend`; row index r ← 0.
- ROW: one row per cycle. r counts 0..N-1. ROW → DONE after r = N-1.
- DONE lasts one cycle with gen_done = 1 and gen_count += 1.
  - DONE → ROW if `pend` is set; `pend` is cleared and r ← 0.
  - DONE → IDLE otherwise.
- Pending: a request seen while not in IDLE sets `pend` (one deep). Further requests while `pend` is set are dropped.
- Row compute in cycle r uses the old generation only:
  - prev = row[N-1] when r = 0, else `save_prev`.
  - cur = row[r].
  - next = `save_row0` when r = N-1, else row[r+1].
  - At the edge ending cycle r: row[r] ← new; `save_prev` ← old row[r]. When r = 0, also `save_row0` ← old row[0].
- Cell rule: count the 8 neighbours, with column wrap c±1 mod N. The count is 4 bits, range 0..8.
  - new = (cnt == 3) | (cur & cnt == 2).
- Edits: a write is applied only in IDLE.
  - In ROW or DONE, writes are dropped silently; upstream observes `busy`.
  - A write and a request in the same IDLE cycle: the write lands at that edge, and the generation includes it.
- Read: `rd_data` ← row[rAddrR][rAddrC] every cycle. During ROW it returns mixed old/new rows; the display tolerates this.

## Timing
- Reset values: all cells 0, state IDLE, r = 0, pend = 0, step_q = 0, save regs 0, rd_data = 0, busy = 0, gen_done = 0, gen_count = 0.
- Request sampled at edge e0 → ROW during cycles e0+1..e0+N. Row r is written at edge e0+r+1.
- DONE occurs in cycle e0+N+1: gen_done = 1 and the new gen_count are visible in that cycle.
- busy is high from e0+1 through e0+N+1 inclusive.
- Total latency is N+1 cycles (65 for K = 6). With `pend` set, back-to-back generations run every N+1 cycles.
- Read latency is 1 cycle.
- Reset asserted mid-generation: the board clears immediately, the partial generation is discarded, and no gen_done is issued.
- gen_count wraps from 2**GEN_W-1 to 0.

## Structure
- Add state encodings `LIFE_IDLE`, `LIFE_ROW`, `LIFE_DONE` and the macro `LIFE_STATE` (2-bit range) to the shared defines header, alongside the existing evolve state constants.
- Sub-module `life_row_next`, parameter K: a combinational N-bit row rule taking prev/cur/next and returning new. It is instantiated once and verified standalone.

## Test plan
- Blinker: cells (10,9), (10,10), (10,11) written, then one step edge → after gen_done the board holds exactly (9,10), (10,10), (11,10), and gen_count = 1.
- Wrap: glider placed at rows 62..63 and 0, cols 62..63 and 0; run 4 generations → the glider is translated by (+1,+1) mod 64, matching a reference model.
- Block still life: 2×2 block at (0,0)..(1,1); step held high for 300 cycles → exactly 1 generation, board unchanged, gen_done seen once.
- Pending/drop: a second step edge at cycle e0+10 → a second generation starts immediately after DONE, gen_count = 2. A third edge during ROW with pend already set is dropped. A write during busy is not applied.
- Simultaneous: write (5,5) = 1 and step edge in the same IDLE cycle → the lone cell dies; (5,5) = 0 after gen_done.
- Reset mid-step: rst pulsed at e0+30 → all reads 0, busy = 0, gen_count = 0, no gen_done pulse.
